// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers the BCD value of each digit from a time-multiplexed,
// active-low 4-digit 7-segment bus; a frame is published only when two full scans agree.
module seg7_scan_decoder #(
  parameter int SETTLE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:6]  seg,
  input  logic [3:0]  digit_sel,
  output logic [15:0] bcd,
  output logic [3:0]  blank,
  output logic [3:0]  err_digit,
  output logic        err,
  output logic        frame_valid
);

  localparam logic [7:0] CNT_TOP = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  mask_reg, mask_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [10:0] pair_reg;
  logic [10:0] pair_now;
  logic [6:0]  seg_vec;
  logic        sel_legal;
  logic        sample;
  logic [1:0]  sample_idx;
  logic [5:0]  sample_code;
  logic [3:0]  slot_we;
  logic        commit_load;

  // Candidate slot layout: [5] blank, [4] invalid, [3:0] nibble.
  logic [5:0]  cand_reg [4];
  logic [15:0] cand_bcd;
  logic [3:0]  cand_blank;
  logic [3:0]  cand_inv;
  logic [23:0] cand_flat;
  logic [23:0] last_reg;
  logic        last_ok_reg;

  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    logic [5:0] code;
    case (s)
      7'b0000001: code = 6'h00;
      7'b1001111: code = 6'h01;
      7'b0010010: code = 6'h02;
      7'b0000110: code = 6'h03;
      7'b1001100: code = 6'h04;
      7'b0100100: code = 6'h05;
      7'b0100000: code = 6'h06;
      7'b0001111: code = 6'h07;
      7'b0000000: code = 6'h08;
      7'b0000100: code = 6'h09;
      7'b1111111: code = 6'b10_1111;
      default:    code = 6'b01_1111;
    endcase
    return code;
  endfunction

  function automatic logic one_low(input logic [3:0] s);
    logic ok;
    case (s)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign seg_vec     = seg;
  assign pair_now    = {digit_sel, seg_vec};
  assign sel_legal   = one_low(digit_sel);
  assign sample_code = decode_seg(seg_vec);

  always_comb begin
    sample_idx = 2'd0;
    case (digit_sel)
      4'b1101: sample_idx = 2'd1;
      4'b1011: sample_idx = 2'd2;
      4'b0111: sample_idx = 2'd3;
      default: sample_idx = 2'd0;
    endcase
  end

  // The counter only climbs while a legal pair is held, so a sample fires once per hold.
  always_comb begin
    cnt_next = cnt_reg;
    if ((pair_now != pair_reg) || !sel_legal) begin
      cnt_next = 8'd0;
    end else if (cnt_reg != CNT_TOP) begin
      cnt_next = cnt_reg + 8'd1;
    end
  end

  assign sample = (cnt_next == CNT_TOP) && (cnt_reg != CNT_TOP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pair_reg <= 11'h7FF;
      cnt_reg  <= 8'd0;
    end else begin
      pair_reg <= pair_now;
      cnt_reg  <= cnt_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= SYNC;
      mask_reg  <= 4'b0000;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mask_next   = mask_reg;
    slot_we     = 4'b0000;
    commit_load = 1'b0;
    case (state_reg)
      SYNC: begin
        if (sample && (sample_idx == 2'd0)) begin
          slot_we    = 4'b0001;
          mask_next  = 4'b0001;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (sample) begin
          slot_we = 4'b0001 << sample_idx;
          if (sample_idx == 2'd0) begin
            mask_next = 4'b0001;
          end else begin
            mask_next = mask_reg | (4'b0001 << sample_idx);
          end
        end
        if (mask_next == 4'b1111) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        // Samples landing here are dropped; the next frame restarts from digit 0.
        commit_load = last_ok_reg && (cand_flat == last_reg);
        mask_next   = 4'b0000;
        state_next  = SYNC;
      end
      default: begin
        mask_next  = 4'b0000;
        state_next = SYNC;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cand_reg[i] <= 6'h00;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (slot_we[i]) begin
          cand_reg[i] <= sample_code;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_flat
    assign cand_bcd[4*gi +: 4] = cand_reg[gi][3:0];
    assign cand_inv[gi]        = cand_reg[gi][4];
    assign cand_blank[gi]      = cand_reg[gi][5];
  end

  assign cand_flat = {cand_blank, cand_inv, cand_bcd};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_reg    <= 24'h000000;
      last_ok_reg <= 1'b0;
    end else if (state_reg == COMMIT) begin
      last_reg    <= cand_flat;
      last_ok_reg <= 1'b1;
    end
  end

  // Published outputs change only on an agreeing commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcd         <= 16'h0000;
      blank       <= 4'b1111;
      err_digit   <= 4'b0000;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= commit_load;
      if (commit_load) begin
        bcd       <= cand_bcd;
        blank     <= cand_blank;
        err_digit <= cand_inv;
      end
    end
  end

  assign err = |err_digit;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: a run-length / frame-level model checked every cycle,
// plus hand-computed expectations after each directed scenario.
module tb_seg7_scan_decoder;

  localparam int SETTLE = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [0:6]  seg = 7'b1111111;
  logic [3:0]  digit_sel = 4'b1111;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic [3:0]  err_digit;
  logic        err;
  logic        frame_valid;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;

  logic [6:0] pat_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  seg7_scan_decoder #(.SETTLE(SETTLE)) dut (
    .clock       (clock),
    .reset       (reset),
    .seg         (seg),
    .digit_sel   (digit_sel),
    .bcd         (bcd),
    .blank       (blank),
    .err_digit   (err_digit),
    .err         (err),
    .frame_valid (frame_valid)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [10:0] run_pair = 11'h7FF;
  int          run_len = 0;
  bit          in_frame = 0, pend = 0, have_last = 0;
  bit          have [4];
  logic [3:0]  c_nib [4], l_nib [4];
  bit          c_bl [4], c_inv [4], l_bl [4], l_inv [4];
  logic [15:0] exp_bcd = 16'h0000;
  logic [3:0]  exp_blank = 4'b1111;
  logic [3:0]  exp_err_digit = 4'b0000;
  logic        exp_fv = 1'b0;

  initial begin : model
    bit         legal, smp, same, all_have;
    int         sd;
    logic [6:0] sv;
    logic [3:0] s_nib;
    bit         s_bl, s_inv;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        run_pair = 11'h7FF; run_len = 0;
        in_frame = 0; pend = 0; have_last = 0;
        for (int i = 0; i < 4; i++) have[i] = 0;
        exp_bcd = 16'h0000; exp_blank = 4'b1111; exp_err_digit = 4'b0000; exp_fv = 1'b0;
      end else begin
        exp_fv = 1'b0;
        sv = seg;
        legal = ($countones(~digit_sel) == 1);
        if (legal && ({digit_sel, sv} == run_pair)) begin
          if (run_len < 1000) run_len++;
        end else begin
          run_pair = {digit_sel, sv};
          run_len = legal ? 1 : 0;
        end
        smp = legal && (run_len == SETTLE);
        sd = 0;
        for (int i = 0; i < 4; i++) if (!digit_sel[i]) sd = i;
        s_nib = 4'hF; s_bl = (sv == 7'b1111111); s_inv = !s_bl;
        for (int k = 0; k < 10; k++) begin
          if (pat_tab[k] == sv) begin s_nib = 4'(k); s_inv = 0; end
        end
        if (pend) begin
          same = 1;
          for (int i = 0; i < 4; i++) begin
            if (c_nib[i] != l_nib[i] || c_bl[i] != l_bl[i] || c_inv[i] != l_inv[i]) same = 0;
          end
          if (have_last && same) begin
            for (int i = 0; i < 4; i++) begin
              exp_bcd[4*i +: 4] = c_nib[i];
              exp_blank[i] = c_bl[i];
              exp_err_digit[i] = c_inv[i];
            end
            exp_fv = 1'b1;
          end
          for (int i = 0; i < 4; i++) begin
            l_nib[i] = c_nib[i]; l_bl[i] = c_bl[i]; l_inv[i] = c_inv[i]; have[i] = 0;
          end
          have_last = 1; pend = 0; in_frame = 0;
        end else if (smp) begin
          if (sd == 0) begin
            in_frame = 1;
            for (int i = 0; i < 4; i++) have[i] = 0;
          end
          if (in_frame) begin
            have[sd] = 1; c_nib[sd] = s_nib; c_bl[sd] = s_bl; c_inv[sd] = s_inv;
            all_have = have[0] && have[1] && have[2] && have[3];
            if (all_have) pend = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clock);
      if (frame_valid) fv_count++;
      checks += 5;
      if (bcd !== exp_bcd) begin
        errors++; $display("FAIL model_bcd t=%0t got=%h exp=%h", $time, bcd, exp_bcd);
      end
      if (blank !== exp_blank) begin
        errors++; $display("FAIL model_blank t=%0t got=%b exp=%b", $time, blank, exp_blank);
      end
      if (err_digit !== exp_err_digit) begin
        errors++; $display("FAIL model_err_digit t=%0t got=%b exp=%b", $time, err_digit, exp_err_digit);
      end
      if (err !== (|exp_err_digit)) begin
        errors++; $display("FAIL model_err t=%0t got=%b exp=%b", $time, err, |exp_err_digit);
      end
      if (frame_valid !== exp_fv) begin
        errors++; $display("FAIL model_frame_valid t=%0t got=%b exp=%b", $time, frame_valid, exp_fv);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end else begin
      $display("ok   %s t=%0t value=%h", name, $time, got);
    end
  endtask

  task automatic hold(input int cycles);
    repeat (cycles) begin @(posedge clock); #1; end
  endtask

  task automatic show(input int d, input logic [6:0] p, input int cycles);
    logic [3:0] one;
    one = 4'b0001 << d;
    digit_sel = ~one;
    seg = p;
    hold(cycles);
  endtask

  task automatic idle(input int cycles);
    digit_sel = 4'b1111;
    seg = 7'b1111111;
    hold(cycles);
  endtask

  task automatic scan_val(input logic [15:0] v, input int h);
    logic [3:0] n;
    for (int d = 0; d < 4; d++) begin
      n = v[4*d +: 4];
      show(d, pat_tab[n], h);
    end
  endtask

  task automatic scan_pats(input logic [6:0] p0, input logic [6:0] p1,
                           input logic [6:0] p2, input logic [6:0] p3, input int h);
    show(0, p0, h); show(1, p1, h); show(2, p2, h); show(3, p3, h);
  endtask

  task automatic restart_scan();
    show(0, pat_tab[9], 6); show(1, pat_tab[8], 6);
    show(0, pat_tab[4], 6); show(1, pat_tab[3], 6);
    digit_sel = 4'b1100; seg = pat_tab[0]; hold(8);
    show(2, pat_tab[2], 6); show(3, pat_tab[1], 6);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int fv0;
    hold(3);
    check("reset_bcd", 32'(bcd), 32'h0000);
    check("reset_blank", 32'(blank), 32'hF);
    check("reset_err_digit", 32'(err_digit), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    reset = 1'b0;
    idle(2);

    fv0 = fv_count;
    scan_val(16'h1234, 6); idle(4);
    check("clean_first_no_fv", 32'(fv_count - fv0), 32'd0);
    scan_val(16'h1234, 6); idle(4);
    check("clean_second_fv", 32'(fv_count - fv0), 32'd1);
    check("clean_bcd", 32'(bcd), 32'h1234);
    check("clean_blank", 32'(blank), 32'h0);
    check("clean_err", 32'(err), 32'h0);

    fv0 = fv_count;
    show(0, pat_tab[4], 6); show(1, pat_tab[3], 6);
    show(2, pat_tab[8], 3); show(2, pat_tab[2], 6);
    show(3, pat_tab[1], 6); idle(4);
    check("glitch_fv", 32'(fv_count - fv0), 32'd1);
    check("glitch_bcd", 32'(bcd), 32'h1234);

    fv0 = fv_count;
    scan_val(16'h1235, 6); idle(4);
    check("mismatch_no_fv", 32'(fv_count - fv0), 32'd0);
    check("mismatch_bcd_held", 32'(bcd), 32'h1234);
    scan_val(16'h1235, 6); idle(4);
    check("mismatch_repeat_fv", 32'(fv_count - fv0), 32'd1);
    check("mismatch_repeat_bcd", 32'(bcd), 32'h1235);

    fv0 = fv_count;
    scan_pats(pat_tab[7], 7'b1111110, pat_tab[5], 7'b1111111, 6); idle(4);
    scan_pats(pat_tab[7], 7'b1111110, pat_tab[5], 7'b1111111, 6); idle(4);
    check("blankinv_fv", 32'(fv_count - fv0), 32'd1);
    check("blankinv_blank", 32'(blank), 32'h8);
    check("blankinv_err_digit", 32'(err_digit), 32'h2);
    check("blankinv_err", 32'(err), 32'h1);
    check("blankinv_bcd", 32'(bcd), 32'hF5F7);

    fv0 = fv_count;
    restart_scan(); idle(4);
    check("restart_first_no_fv", 32'(fv_count - fv0), 32'd0);
    restart_scan(); idle(4);
    check("restart_fv", 32'(fv_count - fv0), 32'd1);
    check("restart_bcd", 32'(bcd), 32'h1234);
    check("restart_err", 32'(err), 32'h0);

    show(0, pat_tab[5], 6); show(1, pat_tab[6], 2);
    reset = 1'b1;
    #2;
    check("midreset_bcd", 32'(bcd), 32'h0000);
    check("midreset_blank", 32'(blank), 32'hF);
    check("midreset_err_digit", 32'(err_digit), 32'h0);
    hold(2);
    reset = 1'b0;
    idle(2);
    fv0 = fv_count;
    scan_val(16'h1234, SETTLE); idle(4);
    check("postreset_first_no_fv", 32'(fv_count - fv0), 32'd0);
    check("postreset_bcd_still_reset", 32'(bcd), 32'h0000);
    scan_val(16'h1234, SETTLE); idle(4);
    check("postreset_second_fv", 32'(fv_count - fv0), 32'd1);
    check("postreset_bcd", 32'(bcd), 32'h1234);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Reverse of the team's BCD-to-7-segment path. It observes a time-multiplexed 4-digit 7-segment bus (segment lines plus active-low digit selects) and recovers the BCD value of each digit. A frame is published only after two identical consecutive full scans. It sits between the display driver outputs and self-test/readback logic, so the design can check what is actually being shown.

## Interface
- SETTLE, default 4: consecutive cycles a `{digit_sel, seg}` pair must be unchanged before it is sampled; legal range 2..255.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- seg  input  [0:6]  segment lines, index 0 = a … 6 = g, active-low (0 = lit).
- digit_sel  input  [3:0]  digit enables, active-low; bit i low selects digit i (digit 0 = units).
- bcd  output  [15:0]  committed frame; `bcd[4i+3:4i]` = digit i.
- blank  output  [3:0]  bit i = 1: digit i committed as blank.
- err_digit  output  [3:0]  bit i = 1: digit i committed as an invalid pattern.
- err  output  1  OR of `err_digit`.
- frame_valid  output  1  one-cycle pulse when a new frame is committed.

## Operation
- Decode table, seg[0:6] string → nibble:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - 1111111→blank (nibble 4'hF, blank bit 1)
  - any other pattern→invalid (nibble 4'hF, invalid bit 1)
- Select legality: `digit_sel` is legal only when exactly one bit is 0. All-ones and multi-low values are illegal.
- Stability counter `cnt` (8 bits):
  - Clears to 0 when `{digit_sel, seg}` differs from the previous cycle or `digit_sel` is illegal.
  - Otherwise increments, saturating at SETTLE-1.
- Sampling:
  - A sample fires in the single cycle the counter transitions to SETTLE-1.
  - A held pair produces exactly one sample.
  - A sample writes the decoded nibble, blank bit and invalid bit into candidate slot i and sets mask bit i.
- FSM states:
  - SYNC (reset state): ignores samples except digit 0. A digit-0 sample stores slot 0, sets mask = 4'b0001 and moves to COLLECT.
  - COLLECT: a digit-0 sample restarts the frame (slot 0 rewritten, mask = 4'b0001). A sample for an already-set digit 1..3 overwrites that slot. When mask = 4'b1111, move to COMMIT.
  - COMMIT (exactly one cycle):
    - If `last_ok` = 1 and candidate == last frame (all nibbles, blank and invalid bits), load `bcd`, `blank`, `err_digit` from the candidate and pulse `frame_valid`.
    - In all cases: last frame ← candidate, `last_ok` ← 1, mask ← 0, next state SYNC.
- Outputs hold their committed values between commits. Mismatching frames never alter them.

## Timing
- Reset values: `bcd` = 16'h0000, `blank` = 4'b1111, `err_digit` = 4'b0000, `err` = 0, `frame_valid` = 0. Internally: state SYNC, `cnt` = 0, mask = 0, `last_ok` = 0.
- Reset is honoured in any state, including mid-frame and during COMMIT. Any partial frame and the stored last frame are discarded.
- Sample latency: a pair first presented in cycle N, and held, samples in cycle N+SETTLE-1; the mask bit is visible at N+SETTLE.
- Commit latency:
  - COMMIT is occupied the cycle after the mask reaches 4'b1111.
  - Outputs and `frame_valid` change at the edge ending COMMIT.
  - `frame_valid` stays high for exactly one cycle and never on consecutive cycles.
- A pair held for fewer than SETTLE cycles is never sampled. Illegal selects between digits are permitted and ignored.
- Samples arriving during the COMMIT cycle are dropped. The next frame needs a fresh digit-0 sample in SYNC.
- `err` is combinational from registered `err_digit`.

## Test plan
- Reset: assert `reset` mid-scan → all outputs at reset values immediately; no `frame_valid` until two full frames follow.
- Clean scan: present digits 0..3 = patterns for 4,3,2,1, each held 6 cycles (SETTLE = 4), twice → exactly one `frame_valid` after the second scan; `bcd` = 16'h1234, `blank` = 0, `err` = 0.
- Glitch rejection: during digit 2 inject a 3-cycle pattern 0000000 → ignored; stable repeat still commits 16'h1234.
- Mismatch: scan 1234 then 1235 → no `frame_valid`, `bcd` unchanged. A third scan of 1235 → pulse, `bcd` = 16'h1235.
- Blank/invalid: digit 3 = 1111111 and digit 1 = 1111110, scanned twice → `blank` = 4'b1000, `err_digit` = 4'b0010, `err` = 1, `bcd[15:12]` = `bcd[7:4]` = 4'hF.
- Frame restart: digits 0,1,0,1,2,3 twice → commit succeeds with the second digit-0/1 values; illegal `digit_sel` = 4'b1100 never produces a sample.
